// File: rtl/fe25519_pkg.sv
// Shared constants for ref10-style GF(2^255-19) arithmetic: limb geometry,
// controller states, the fe_sq product schedule and the carry-chain schedule.
package fe25519_pkg;
  localparam int NLIMB      = 10;
  localparam int LIMB_W     = 32;
  localparam int N_SQ_TERMS = 55;
  localparam int N_PRE      = 13;
  localparam int N_CARRY    = 12;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRECOMP, S_MAC, S_DOUBLE, S_CARRY, S_WBACK, S_FINISH
  } sq_state_t;

  // Plain limbs occupy codes 0..9; precomputed multiples follow in the same
  // order as the precompute schedule, so code 10+p reads precompute slot p.
  typedef enum logic [4:0] {
    OP_F0, OP_F1, OP_F2, OP_F3, OP_F4, OP_F5, OP_F6, OP_F7, OP_F8, OP_F9,
    OP_F0_2, OP_F1_2, OP_F2_2, OP_F3_2, OP_F4_2, OP_F5_2, OP_F6_2, OP_F7_2,
    OP_F5_38, OP_F6_19, OP_F7_38, OP_F8_19, OP_F9_38
  } operand_t;

  typedef enum logic [1:0] {W_NONE, W_PRE, W_MAC} wr_kind_t;

  typedef struct packed {
    operand_t   a;
    operand_t   b;
    logic [3:0] tgt;
  } sq_term_t;

  localparam logic [3:0] PRE_SRC [N_PRE] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  localparam logic [5:0] PRE_MUL [N_PRE] = '{
    6'd2, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2, 6'd38, 6'd19, 6'd38, 6'd19, 6'd38};

  // Row-major over (i<=j); the first entries avoid 19*f8 / 38*f9, which may
  // still be in flight from the precompute phase when MAC starts.
  localparam sq_term_t SQ_SCHED [N_SQ_TERMS] = '{
    '{OP_F0,   OP_F0,    4'd0}, '{OP_F0_2, OP_F1,    4'd1}, '{OP_F0_2, OP_F2,    4'd2},
    '{OP_F0_2, OP_F3,    4'd3}, '{OP_F0_2, OP_F4,    4'd4}, '{OP_F0_2, OP_F5,    4'd5},
    '{OP_F0_2, OP_F6,    4'd6}, '{OP_F0_2, OP_F7,    4'd7}, '{OP_F0_2, OP_F8,    4'd8},
    '{OP_F0_2, OP_F9,    4'd9},
    '{OP_F1_2, OP_F1,    4'd2}, '{OP_F1_2, OP_F2,    4'd3}, '{OP_F1_2, OP_F3_2,  4'd4},
    '{OP_F1_2, OP_F4,    4'd5}, '{OP_F1_2, OP_F5_2,  4'd6}, '{OP_F1_2, OP_F6,    4'd7},
    '{OP_F1_2, OP_F7_2,  4'd8}, '{OP_F1_2, OP_F8,    4'd9}, '{OP_F1_2, OP_F9_38, 4'd0},
    '{OP_F2,   OP_F2,    4'd4}, '{OP_F2_2, OP_F3,    4'd5}, '{OP_F2_2, OP_F4,    4'd6},
    '{OP_F2_2, OP_F5,    4'd7}, '{OP_F2_2, OP_F6,    4'd8}, '{OP_F2_2, OP_F7,    4'd9},
    '{OP_F2_2, OP_F8_19, 4'd0}, '{OP_F2,   OP_F9_38, 4'd1},
    '{OP_F3_2, OP_F3,    4'd6}, '{OP_F3_2, OP_F4,    4'd7}, '{OP_F3_2, OP_F5_2,  4'd8},
    '{OP_F3_2, OP_F6,    4'd9}, '{OP_F3_2, OP_F7_38, 4'd0}, '{OP_F3_2, OP_F8_19, 4'd1},
    '{OP_F3_2, OP_F9_38, 4'd2},
    '{OP_F4,   OP_F4,    4'd8}, '{OP_F4_2, OP_F5,    4'd9}, '{OP_F4_2, OP_F6_19, 4'd0},
    '{OP_F4,   OP_F7_38, 4'd1}, '{OP_F4_2, OP_F8_19, 4'd2}, '{OP_F4,   OP_F9_38, 4'd3},
    '{OP_F5,   OP_F5_38, 4'd0}, '{OP_F5_2, OP_F6_19, 4'd1}, '{OP_F5_2, OP_F7_38, 4'd2},
    '{OP_F5_2, OP_F8_19, 4'd3}, '{OP_F5_2, OP_F9_38, 4'd4},
    '{OP_F6,   OP_F6_19, 4'd2}, '{OP_F6,   OP_F7_38, 4'd3}, '{OP_F6_2, OP_F8_19, 4'd4},
    '{OP_F6,   OP_F9_38, 4'd5},
    '{OP_F7,   OP_F7_38, 4'd4}, '{OP_F7_2, OP_F8_19, 4'd5}, '{OP_F7_2, OP_F9_38, 4'd6},
    '{OP_F8,   OP_F8_19, 4'd6}, '{OP_F8,   OP_F9_38, 4'd7},
    '{OP_F9,   OP_F9_38, 4'd8}};

  localparam logic [3:0] CARRY_SRC [N_CARRY] = '{
    4'd0, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8, 4'd9, 4'd0};
  localparam logic [3:0] CARRY_DST [N_CARRY] = '{
    4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8, 4'd5, 4'd9, 4'd0, 4'd1};
  localparam logic [4:0] CARRY_SHIFT [N_CARRY] = '{
    5'd26, 5'd26, 5'd25, 5'd25, 5'd26, 5'd26, 5'd25, 5'd25, 5'd26, 5'd26, 5'd25, 5'd26};
  localparam logic CARRY_MUL19 [N_CARRY] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
endpackage

// File: rtl/fe_carry_chain.sv
// Sequential ref10 carry chain: 12 stages of (compute carry, add to dst,
// subtract from src), emitting one accumulator write per add/subtract cycle.
module fe_carry_chain import fe25519_pkg::*; #(
  parameter int ACC_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic signed [ACC_W-1:0] acc [NLIMB],
  output logic                    wr_en,
  output logic [3:0]              wr_idx,
  output logic signed [ACC_W-1:0] wr_data,
  output logic                    last
);
  localparam logic signed [ACC_W-1:0] NINETEEN = ACC_W'(19);

  logic [3:0]              stage;
  logic [1:0]              sub;
  logic signed [ACC_W-1:0] carry;
  logic [3:0]              src, dst;
  logic [4:0]              sh;
  logic signed [ACC_W-1:0] rounded;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    src     = CARRY_SRC[stage];
    dst     = CARRY_DST[stage];
    sh      = CARRY_SHIFT[stage];
    rounded = acc[src] + (ACC_W'(1) << (sh - 5'd1));
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (run && sub == 2'd1) begin
      wr_en   = 1'b1;
      wr_idx  = dst;
      wr_data = acc[dst] + (CARRY_MUL19[stage] ? carry * NINETEEN : carry);
    end else if (run && sub == 2'd2) begin
      wr_en   = 1'b1;
      wr_idx  = src;
      wr_data = acc[src] - (carry << sh);
    end
    last = run && stage == 4'(N_CARRY - 1) && sub == 2'd2;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage <= '0;
      sub   <= '0;
      carry <= '0;
    end else if (!run) begin
      stage <= '0;
      sub   <= '0;
    end else begin
      if (sub == 2'd0) carry <= rounded >>> sh;
      if (sub == 2'd2) begin
        sub   <= '0;
        stage <= (stage == 4'(N_CARRY - 1)) ? '0 : stage + 4'd1;
      end else begin
        sub <= sub + 2'd1;
      end
    end
  end
endmodule

// File: rtl/fe_sq_pow2k.sv
// Iterated field squarer h = f^(2^k) (optionally doubled on the last pass)
// around one shared signed multiplier with MUL_PIPE output stages.
module fe_sq_pow2k import fe25519_pkg::*; #(
  parameter int K_W      = 8,
  parameter int MUL_PIPE = 1,
  parameter int ACC_W    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [K_W-1:0]            k,
  input  logic                      dbl,
  input  logic [NLIMB*LIMB_W-1:0]   f,
  output logic [NLIMB*LIMB_W-1:0]   h,
  output logic                      busy,
  output logic                      done
);
  localparam int         PROD_W   = 2 * LIMB_W;
  localparam logic [5:0] PRE_LAST = 6'(N_PRE - 1);
  localparam logic [5:0] MAC_LAST = 6'(N_SQ_TERMS + MUL_PIPE - 1);

  sq_state_t                state;
  logic [5:0]               cnt;
  logic [K_W-1:0]           iter;
  logic                     dbl_r;
  logic signed [LIMB_W-1:0] f_reg   [NLIMB];
  logic signed [LIMB_W-1:0] pre_reg [N_PRE];
  logic signed [ACC_W-1:0]  h_acc   [NLIMB];

  logic signed [PROD_W-1:0] mul_p  [MUL_PIPE];
  wr_kind_t                 kind_p [MUL_PIPE];
  logic [3:0]               idx_p  [MUL_PIPE];

  logic signed [LIMB_W-1:0] iss_a, iss_b;
  logic signed [PROD_W-1:0] iss_prod;
  wr_kind_t                 iss_kind;
  logic [3:0]               iss_idx;

  logic                     carry_run, cc_wr_en, cc_last;
  logic [3:0]               cc_wr_idx;
  logic signed [ACC_W-1:0]  cc_wr_data;

  function automatic logic signed [LIMB_W-1:0] operand_val(input operand_t op);
    if (op < OP_F0_2) return f_reg[op[3:0]];
    return pre_reg[4'(op - OP_F0_2)];
  endfunction

  always_comb begin
    iss_a    = '0;
    iss_b    = '0;
    iss_kind = W_NONE;
    iss_idx  = '0;
    if (state == S_PRECOMP) begin
      iss_a    = f_reg[PRE_SRC[cnt[3:0]]];
      iss_b    = LIMB_W'(PRE_MUL[cnt[3:0]]);
      iss_kind = W_PRE;
      iss_idx  = cnt[3:0];
    end else if (state == S_MAC && cnt < 6'(N_SQ_TERMS)) begin
      iss_a    = operand_val(SQ_SCHED[cnt].a);
      iss_b    = operand_val(SQ_SCHED[cnt].b);
      iss_kind = W_MAC;
      iss_idx  = SQ_SCHED[cnt].tgt;
    end
  end

  assign iss_prod  = PROD_W'(iss_a) * PROD_W'(iss_b);
  assign carry_run = (state == S_CARRY);

  fe_carry_chain #(.ACC_W(ACC_W)) u_carry (
    .clk     (clk),
    .reset   (reset),
    .run     (carry_run),
    .acc     (h_acc),
    .wr_en   (cc_wr_en),
    .wr_idx  (cc_wr_idx),
    .wr_data (cc_wr_data),
    .last    (cc_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the limb, precompute and accumulator arrays are reset like any
      // other register so an aborted run leaves no stale state behind.
      state <= S_IDLE;
      cnt   <= '0;
      iter  <= '0;
      dbl_r <= 1'b0;
      h     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NLIMB; i++) begin
        f_reg[i] <= '0;
        h_acc[i] <= '0;
      end
      for (int i = 0; i < N_PRE; i++) pre_reg[i] <= '0;
      for (int i = 0; i < MUL_PIPE; i++) begin
        mul_p[i]  <= '0;
        kind_p[i] <= W_NONE;
        idx_p[i]  <= '0;
      end
    end else begin
      done <= 1'b0;

      mul_p[0]  <= iss_prod;
      kind_p[0] <= iss_kind;
      idx_p[0]  <= iss_idx;
      for (int i = 1; i < MUL_PIPE; i++) begin
        mul_p[i]  <= mul_p[i-1];
        kind_p[i] <= kind_p[i-1];
        idx_p[i]  <= idx_p[i-1];
      end
      // Pipe-tail writes are tagged, so precompute results may land in MAC.
      if (kind_p[MUL_PIPE-1] == W_PRE)
        pre_reg[idx_p[MUL_PIPE-1]] <= mul_p[MUL_PIPE-1][LIMB_W-1:0];
      if (kind_p[MUL_PIPE-1] == W_MAC)
        h_acc[idx_p[MUL_PIPE-1]] <= h_acc[idx_p[MUL_PIPE-1]] + ACC_W'(mul_p[MUL_PIPE-1]);
      if (cc_wr_en) h_acc[cc_wr_idx] <= cc_wr_data;

      case (state)
        S_IDLE: begin
          busy <= start;
          if (start) begin
            for (int i = 0; i < NLIMB; i++) f_reg[i] <= f[LIMB_W*i +: LIMB_W];
            iter  <= k;
            dbl_r <= dbl;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (iter == '0) begin
            state <= S_FINISH;
          end else begin
            for (int i = 0; i < NLIMB; i++) h_acc[i] <= '0;
            cnt   <= '0;
            state <= S_PRECOMP;
          end
        end
        S_PRECOMP: begin
          if (cnt == PRE_LAST) begin
            cnt   <= '0;
            state <= S_MAC;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_MAC: begin
          if (cnt == MAC_LAST) begin
            cnt   <= '0;
            state <= (dbl_r && iter == K_W'(1)) ? S_DOUBLE : S_CARRY;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_DOUBLE: begin
          for (int i = 0; i < NLIMB; i++) h_acc[i] <= h_acc[i] <<< 1;
          state <= S_CARRY;
        end
        S_CARRY: begin
          if (cc_last) state <= S_WBACK;
        end
        S_WBACK: begin
          for (int i = 0; i < NLIMB; i++) begin
            f_reg[i] <= h_acc[i][LIMB_W-1:0];
            h_acc[i] <= '0;
          end
          iter  <= iter - K_W'(1);
          state <= (iter == K_W'(1)) ? S_FINISH : S_PRECOMP;
        end
        S_FINISH: begin
          for (int i = 0; i < NLIMB; i++) h[LIMB_W*i +: LIMB_W] <= f_reg[i];
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fe_sq_pow2k.sv
// Self-checking bench for fe_sq_pow2k: directed cases, randomized runs against
// an arithmetic ref10 squaring model, busy-start rejection and mid-run reset.
module tb_fe_sq_pow2k;
  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   k     = '0;
  logic         dbl   = 1'b0;
  logic [319:0] f     = '0;
  logic [319:0] h;
  logic         busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int C_SRC [12] = '{0, 4, 1, 5, 2, 6, 3, 7, 4, 8, 9, 0};
  localparam int C_DST [12] = '{1, 5, 2, 6, 3, 7, 4, 8, 5, 9, 0, 1};
  localparam int C_SH  [12] = '{26, 26, 25, 25, 26, 26, 25, 25, 26, 26, 25, 26};

  always #5 clk = ~clk;

  fe_sq_pow2k #(.K_W(8), .MUL_PIPE(1), .ACC_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .k     (k),
    .dbl   (dbl),
    .f     (f),
    .h     (h),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Radix-2^25.5 squaring from the coefficient rule, then the ref10 carry.
  function automatic logic [319:0] ref_pow2k(input logic [319:0] fin, input int kk, input bit dd);
    longint fl [10];
    longint hl [10];
    longint coef, c;
    logic [319:0] r;
    for (int i = 0; i < 10; i++) fl[i] = longint'($signed(fin[32*i +: 32]));
    for (int it = 0; it < kk; it++) begin
      for (int i = 0; i < 10; i++) hl[i] = 0;
      for (int i = 0; i < 10; i++)
        for (int j = i; j < 10; j++) begin
          coef = (i == j) ? 1 : 2;
          if ((i % 2 == 1) && (j % 2 == 1)) coef = coef * 2;
          if (i + j >= 10) coef = coef * 19;
          hl[(i + j) % 10] += coef * fl[i] * fl[j];
        end
      if (dd && it == kk - 1)
        for (int i = 0; i < 10; i++) hl[i] = hl[i] * 2;
      for (int s = 0; s < 12; s++) begin
        c = (hl[C_SRC[s]] + (longint'(1) << (C_SH[s] - 1))) >>> C_SH[s];
        hl[C_DST[s]] += (s == 10) ? c * 19 : c;
        hl[C_SRC[s]] -= c * (longint'(1) << C_SH[s]);
      end
      for (int i = 0; i < 10; i++) fl[i] = longint'(int'(hl[i]));
    end
    for (int i = 0; i < 10; i++) r[32*i +: 32] = fl[i][31:0];
    return r;
  endfunction

  function automatic logic [319:0] rand_fe();
    logic [319:0] r;
    int v;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) v = int'($urandom_range(32'd67108864, 0)) - 33554432;
      else            v = int'($urandom_range(32'd33554432, 0)) - 16777216;
      r[32*i +: 32] = v;
    end
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [319:0] fin, input int kk, input bit dd,
                        input logic [319:0] exp_h, input bit poke);
    int exp_lat, lat, extra;
    bit got;
    exp_lat = 2 + 106 * kk + ((dd && kk > 0) ? 1 : 0);
    @(negedge clk);
    f = fin; k = kk[7:0]; dbl = dd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy_on"}, 320'(busy), 320'(1));
    lat = 0; got = 1'b0;
    while (!got && lat < exp_lat + 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1'b1;
      start = poke && !got && lat > 2 && lat < exp_lat - 3 && ($urandom_range(3, 0) == 0);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 320'(got), 320'(1));
    check({tag, "_latency"}, 320'(lat), 320'(exp_lat));
    check({tag, "_h"}, h, exp_h);
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (done) extra++;
    end
    check({tag, "_no_extra_done"}, 320'(extra), 320'(0));
    check({tag, "_busy_off"}, 320'(busy), 320'(0));
    check({tag, "_h_hold"}, h, exp_h);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [319:0] fr, one_f;
    bit dd;
    int extra;
    int ks [4] = '{1, 5, 50, 5};

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_h", h, 320'(0));
    check("reset_busy", 320'(busy), 320'(0));
    check("reset_done", 320'(done), 320'(0));
    @(negedge clk) reset = 1'b1;

    run_op("one_k1", 320'(1), 1, 1'b0, 320'(1), 1'b0);
    run_op("two_k3", 320'(2), 3, 1'b0, 320'(256), 1'b0);
    one_f = 320'(1) << 32;
    run_op("carry_2p26", 320'(8192), 1, 1'b0, one_f, 1'b0);
    run_op("three_dbl", 320'(3), 1, 1'b1, 320'(18), 1'b0);
    run_op("three_k0_dbl", 320'(3), 0, 1'b1, 320'(3), 1'b0);

    foreach (ks[i]) begin
      fr = rand_fe();
      dd = 1'($urandom_range(1, 0));
      run_op($sformatf("rand_k%0d", ks[i]), fr, ks[i], dd, ref_pow2k(fr, ks[i], dd), 1'b1);
    end

    fr = rand_fe();
    run_op("rand_k0", fr, 0, 1'b0, fr, 1'b0);

    // Abort a k=4 run at cycle 60 after accept.
    fr = rand_fe();
    @(negedge clk);
    f = fr; k = 8'd4; dbl = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (59) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_h", h, 320'(0));
    check("abort_busy", 320'(busy), 320'(0));
    check("abort_done", 320'(done), 320'(0));
    @(negedge clk) reset = 1'b1;
    extra = 0;
    repeat (450) begin
      @(posedge clk);
      #1 if (done) extra++;
    end
    check("abort_no_done", 320'(extra), 320'(0));

    fr = rand_fe();
    run_op("after_abort", fr, 4, 1'b0, ref_pow2k(fr, 4, 1'b0), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
